demux: RTL

Registered 1-to-2 stream demultiplexer with valid/ready handshakes, the dual of the datapath `mux`. It accepts one input word per cycle and a select bit, then steers the word to output port 0 or 1. Each output has its own 2-entry FIFO, so a stalled consumer on one port does not block traffic to the other. It sits between a single producer and two consumers in the CPU datapath, for example a write-back path fanning out to two destinations.

---
 rtl/demux.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/demux.sv
`default_nettype none
// ============================================================================
// Module   : demux
// Brief    : Registered 1-to-2 stream demultiplexer with valid/ready
//            handshakes. Each output port owns a 2-entry FIFO so that a
//            stalled consumer on one port never blocks the other port.
//            Optional per-port delivery counters are enabled by defining
//            DEMUX_STATS_EN (adds count0/count1 ports).
// Revision : 1.0 - initial release
// ============================================================================
module demux #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      count0,
    output logic [15:0]      count1
`endif
);

    // Per-FIFO occupancy
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    logic [WIDTH-1:0] w_head      [2];
    logic             w_full      [2];
    logic             w_valid     [2];
    logic             w_out_ready [2];
`ifdef DEMUX_STATS_EN
    logic [15:0]      w_count     [2];
`endif

    assign w_out_ready[0] = out0_ready;
    assign w_out_ready[1] = out1_ready;

    // Ready looks only at registered occupancy of the selected FIFO, so
    // there is no combinational path from outN_ready to in_ready. A FULL
    // FIFO being popped this cycle still refuses the push (one bubble).
    assign in_ready = !reset && !w_full[in_sel];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_port
            occ_t             r_state;
            occ_t             w_state_nxt;
            logic [WIDTH-1:0] r_head;
            logic [WIDTH-1:0] r_tail;
            logic             w_push;
            logic             w_pop;

            assign w_push = in_valid && in_ready && (in_sel == 1'(g));
            assign w_pop  = (r_state != S_EMPTY) && w_out_ready[g] && !reset;

            // Occupancy transitions on push/pop
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    S_EMPTY: begin
                        if (w_push) w_state_nxt = S_ONE;
                    end
                    S_ONE: begin
                        if (w_push && !w_pop)      w_state_nxt = S_FULL;
                        else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
                    end
                    S_FULL: begin
                        if (w_pop) w_state_nxt = S_ONE;
                    end
                    default: w_state_nxt = S_EMPTY;
                endcase
            end

            // Occupancy state register
            always_ff @(posedge clock) begin
                if (reset) r_state <= S_EMPTY;
                else       r_state <= w_state_nxt;
            end

            // Head/tail storage; head drives the output directly, and it is
            // left untouched when the FIFO drains so the output holds.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_head <= '0;
                    r_tail <= '0;
                end else begin
                    case (r_state)
                        S_EMPTY: begin
                            if (w_push) r_head <= in_data;
                        end
                        S_ONE: begin
                            if (w_push && w_pop) r_head <= in_data;
                            else if (w_push)     r_tail <= in_data;
                        end
                        S_FULL: begin
                            if (w_pop) r_head <= r_tail;
                        end
                        default: begin
                            r_head <= r_head;
                        end
                    endcase
                end
            end

            assign w_full[g]  = (r_state == S_FULL);
            assign w_valid[g] = (r_state != S_EMPTY);
            assign w_head[g]  = r_head;

`ifdef DEMUX_STATS_EN
            logic [15:0] r_count;

            // Delivered-word counter, wraps naturally at 16 bits
            always_ff @(posedge clock) begin
                if (reset)      r_count <= 16'd0;
                else if (w_pop) r_count <= r_count + 16'd1;
            end

            assign w_count[g] = r_count;
`endif
        end
    endgenerate

    assign out0_data  = w_head[0];
    assign out0_valid = w_valid[0];
    assign out1_data  = w_head[1];
    assign out1_valid = w_valid[1];
`ifdef DEMUX_STATS_EN
    assign count0     = w_count[0];
    assign count1     = w_count[1];
`endif

endmodule
`default_nettype wire
